// File: rtl/dmem_responder_if.sv
// Requester-side bus for the M-stage data-memory port.
// The master drives the address and store fields. The slave returns combinational load data.
interface dmem_responder_if;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [2:0]  access_type;
    logic [31:0] q_dmem;

    modport master (output address_dmem, data, wren, access_type, input  q_dmem);
    modport slave  (input  address_dmem, data, wren, access_type, output q_dmem);
endinterface

// File: rtl/dmem_responder.sv
// Zero-wait RV32 data-memory slave: word RAM with byte lanes, load extension, misalign trap.
// Optional register window (CYCLE/STORES/TOHOST/ERR_ADDR) is built when DMEM_MMIO_EN is defined.
module dmem_responder #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_F000
) (
    input  logic            clock,
    input  logic            reset,
    dmem_responder_if.slave bus,
    output logic            misalign_err,
    output logic [31:0]     err_addr,
    output logic            halt
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [31:0]       addr;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    logic [2:0]        at;
    logic              is_b, is_h, is_w, zext, misal;

    assign addr = bus.address_dmem;
    assign idx  = addr[ADDR_W+1:2];
    assign lane = addr[1:0];
    assign at   = bus.access_type;

    // Undefined funct3 encodings fall through to word size.
    always_comb begin
        is_b  = (at == 3'b000) || (at == 3'b100);
        is_h  = (at == 3'b001) || (at == 3'b101);
        is_w  = !is_b && !is_h;
        zext  = at[2];
        misal = (is_h && addr[0]) || (is_w && (addr[1:0] != 2'b00));
    end

    logic        mmio_hit;
    logic [31:0] mmio_rd;
    logic        ram_we;

    // ---------------- RAM ----------------
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rword;
    logic [31:0] rshift;
    logic [15:0] rhalf;
    logic [31:0] ram_rd;
    logic [3:0]  be;
    logic [31:0] wdata;

    assign rword  = mem_q[idx];
    assign rshift = rword >> {lane, 3'b000};
    assign rhalf  = addr[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        if (is_b)
            ram_rd = {{24{~zext & rshift[7]}}, rshift[7:0]};
        else if (is_h)
            ram_rd = {{16{~zext & rhalf[15]}}, rhalf};
        else
            ram_rd = rword;
    end

    // Store data is right-aligned; replicate it so the byte enables pick the right copy.
    always_comb begin
        if (is_b) begin
            be    = 4'b0001 << lane;
            wdata = {4{bus.data[7:0]}};
        end else if (is_h) begin
            be    = 4'b0011 << lane;
            wdata = {2{bus.data[15:0]}};
        end else begin
            be    = 4'b1111;
            wdata = bus.data;
        end
    end

    assign ram_we = reset && bus.wren && !misal && !mmio_hit;

    always_ff @(posedge clock) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // ---------------- misalign trap ----------------
    logic        err_q, err_d;
    logic [31:0] err_addr_q, err_addr_d;

    always_comb begin
        err_d      = err_q | misal;
        err_addr_d = (misal && !err_q) ? addr : err_addr_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            err_q      <= 1'b0;
            err_addr_q <= 32'd0;
        end else begin
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign misalign_err = err_q;
    assign err_addr     = err_addr_q;

`ifdef DMEM_MMIO_EN
    // ---------------- register window ----------------
    logic [31:0] cycle_q,  cycle_d;
    logic [31:0] stores_q, stores_d;
    logic [31:0] tohost_q, tohost_d;
    logic        halt_q,   halt_d;
    logic        tohost_we;

    assign mmio_hit = (addr[31:12] == MMIO_BASE[31:12]);

    always_comb begin
        mmio_rd = 32'd0;
        if (is_w) begin
            case (addr[11:2])
                10'd0:   mmio_rd = cycle_q;
                10'd1:   mmio_rd = stores_q;
                10'd2:   mmio_rd = tohost_q;
                10'd3:   mmio_rd = err_addr_q;
                default: mmio_rd = 32'd0;
            endcase
        end
    end

    always_comb begin
        tohost_we = bus.wren && mmio_hit && is_w && !misal && (addr[11:2] == 10'd2);
        cycle_d   = cycle_q + 32'd1;
        stores_d  = stores_q + 32'(ram_we);
        tohost_d  = tohost_we ? bus.data : tohost_q;
        halt_d    = halt_q | (tohost_we && (bus.data != 32'd0));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cycle_q  <= 32'd0;
            stores_q <= 32'd0;
            tohost_q <= 32'd0;
            halt_q   <= 1'b0;
        end else begin
            cycle_q  <= cycle_d;
            stores_q <= stores_d;
            tohost_q <= tohost_d;
            halt_q   <= halt_d;
        end
    end

    assign halt = halt_q;
`else
    logic unused_bits;

    assign mmio_hit    = 1'b0;
    assign mmio_rd     = 32'd0;
    assign halt        = 1'b0;
    assign unused_bits = ^{addr[31:ADDR_W+2], MMIO_BASE};
`endif

    always_comb begin
        if (misal)
            bus.q_dmem = 32'd0;
        else if (mmio_hit)
            bus.q_dmem = mmio_rd;
        else
            bus.q_dmem = ram_rd;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: lane loads/stores, misalign trap, reset suppression.
// The register-window checks are compiled only when DMEM_MMIO_EN is defined.
module tb_dmem_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        misalign_err;
    logic        halt;
    logic [31:0] err_addr;
    int          n_chk  = 0;
    int          n_fail = 0;

    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    dmem_responder_if bus();

    dmem_responder #(.ADDR_W(10), .MMIO_BASE(32'hFFFF_F000)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .misalign_err(misalign_err),
        .err_addr    (err_addr),
        .halt        (halt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we, input logic [2:0] at);
        bus.address_dmem = a;
        bus.data         = d;
        bus.wren         = we;
        bus.access_type  = at;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] at);
        drive(a, d, 1'b1, at);
        tick();
        bus.wren = 1'b0;
    endtask

    task automatic ld(input string tag, input logic [31:0] a, input logic [2:0] at, input logic [31:0] exp);
        drive(a, 32'd0, 1'b0, at);
        #1;
        chk(tag, bus.q_dmem, exp);
        tick();
    endtask

    initial begin
        drive(32'h0, 32'h0, 1'b0, W);
        tick();
        tick();
        chk("rst_err",   {31'd0, misalign_err}, 32'd0);
        chk("rst_eaddr", err_addr, 32'd0);
        chk("rst_halt",  {31'd0, halt}, 32'd0);
        reset = 1'b1;

        // lane extraction and extension
        st(32'h10, 32'h8899AABB, W);
        ld("lb_11",  32'h11, B,  32'hFFFFFFAA);
        ld("lbu_11", 32'h11, BU, 32'h000000AA);
        ld("lh_12",  32'h12, H,  32'hFFFF8899);
        ld("lhu_12", 32'h12, HU, 32'h00008899);
        ld("lw_10",  32'h10, W,  32'h8899AABB);

        // partial stores touch only their lanes; upper data bits are ignored
        st(32'h13, 32'hFFFFFF11, B);
        ld("lw_sb",  32'h10, W,  32'h1199AABB);
        st(32'h10, 32'hABCD7E01, H);
        ld("lw_sh",  32'h10, W,  32'h11997E01);
        ld("lb_10",  32'h10, B,  32'h00000001);
        ld("lb_11b", 32'h11, B,  32'h0000007E);
        ld("lh_10",  32'h10, H,  32'h00007E01);
        ld("lbu_13", 32'h13, BU, 32'h00000011);

        // read-during-write returns old data this cycle, new data next
        st(32'h20, 32'hCAFEF00D, W);
        drive(32'h20, 32'h01020304, 1'b1, W);
        #1;
        chk("rdw_old", bus.q_dmem, 32'hCAFEF00D);
        tick();
        bus.wren = 1'b0;
        #1;
        chk("rdw_new", bus.q_dmem, 32'h01020304);
        ld("lw_at7", 32'h20, 3'b111, 32'h01020304);

        // address wrap above the RAM index
        st(32'h1030, 32'h00000055, W);
        ld("lw_wrap", 32'h30, W, 32'h00000055);

        // misalign: first error address wins, no state change
        st(32'h08, 32'h0BADF00D, W);
        chk("pre_err", {31'd0, misalign_err}, 32'd0);
        ld("lw_06_mis", 32'h06, W, 32'h0);
        chk("mis_err",   {31'd0, misalign_err}, 32'd1);
        chk("mis_eaddr", err_addr, 32'h06);
        drive(32'h0B, 32'h1234, 1'b1, H);
        #1;
        chk("sh_0b_q", bus.q_dmem, 32'h0);
        tick();
        bus.wren = 1'b0;
        chk("mis_eaddr2", err_addr, 32'h06);
        ld("lw_08_keep", 32'h08, W, 32'h0BADF00D);
        ld("lw_at3_mis", 32'h22, 3'b011, 32'h0);
        chk("mis_eaddr3", err_addr, 32'h06);
        ld("lb_odd_ok", 32'h0B, BU, 32'h0000000B);
        chk("halt_def", {31'd0, halt}, 32'd0);

        // store during reset is suppressed
        st(32'h0, 32'h13572468, W);
        reset = 1'b0;
        drive(32'h0, 32'hDEADBEEF, 1'b1, W);
        tick();
        chk("rst2_err",   {31'd0, misalign_err}, 32'd0);
        chk("rst2_eaddr", err_addr, 32'd0);
        reset = 1'b1;
        bus.wren = 1'b0;
        ld("lw_0_rst", 32'h0, W, 32'h13572468);

`ifdef DMEM_MMIO_EN
        ld("stores_rst", 32'hFFFFF004, W, 32'd0);

        reset = 1'b0;
        drive(32'h0, 32'h0, 1'b0, W);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        ld("cycle_5", 32'hFFFFF000, W, 32'd5);
        st(32'h40, 32'h1, W);
        st(32'h41, 32'h2, B);
        st(32'h42, 32'h3, H);
        st(32'hFFFFF004, 32'h99, W);
        ld("stores_3", 32'hFFFFF004, W, 32'd3);

        st(32'hFFFFF008, 32'h0, W);
        chk("halt_w0", {31'd0, halt}, 32'd0);
        st(32'hFFFFF008, 32'h1, W);
        chk("halt_w1", {31'd0, halt}, 32'd1);
        ld("tohost_1", 32'hFFFFF008, W, 32'd1);
        st(32'hFFFFF008, 32'h0, W);
        chk("halt_stk", {31'd0, halt}, 32'd1);
        st(32'hFFFFF008, 32'h5, B);
        ld("tohost_sb", 32'hFFFFF008, W, 32'd0);
        ld("mmio_lb",   32'hFFFFF008, B, 32'd0);
        chk("mmio_noerr", {31'd0, misalign_err}, 32'd0);
        ld("mmio_undef", 32'hFFFFF010, W, 32'd0);
        ld("mmio_eaddr", 32'hFFFFF00C, W, 32'd0);
        ld("stores_mm", 32'hFFFFF004, W, 32'd3);
        reset = 1'b0;
        tick();
        chk("halt_rst", {31'd0, halt}, 32'd0);
        reset = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
